vx_cmt_csr_counter: RTL and testbench
=====================================

// Module: vx_cmt_csr_counter
// PURPOSE
//   Parametrised commit-to-CSR aggregation stage. Collects per-unit commit events from
//   NUM_CHANNELS commit channels and popcounts each channel's thread mask. Emits a
//   registered per-cycle commit_valid/commit_size pair and maintains the architectural
//   instret counter. The counter is software-writable and has a wrap or saturate mode.
//   Sits between the commit arbiters and the CSR data unit.
// PARAMETERS
//   NUM_CHANNELS  6   number of commit channels (alu, lsu, csr, fpu, gpu, ...)
//   NUM_THREADS   4   threads per warp; width of each channel thread mask
//   CNT_WIDTH     64  instret width; legal range 33..64
//   SATURATE      0   0: counter wraps modulo 2^CNT_WIDTH; 1: counter clamps at all-ones
// PORTS
//   clk           in   1                          clock, all state on rising edge
//   reset_n       in   1                          asynchronous active-low reset
//   ch_valid      in   NUM_CHANNELS               channel i commits this cycle
//   ch_tmask      in   NUM_CHANNELS*NUM_THREADS   channel i mask at [i*NUM_THREADS +: NUM_THREADS]
//   inhibit       in   1                          counting inhibit (mcountinhibit.IR)
//   csr_wr_en     in   1                          software write to instret
//   csr_wr_hi     in   1                          0: write bits [31:0]; 1: write bits [CNT_WIDTH-1:32]
//   csr_wr_data   in   32                         write data; hi write uses low CNT_WIDTH-32 bits
//   commit_valid  out  1                          registered: at least one lane committed
//   commit_size   out  SIZE_W                     registered lanes committed; SIZE_W=$clog2(NUM_CHANNELS*NUM_THREADS+1)
//   instret       out  CNT_WIDTH                  instructions-retired counter
//   instret_ovf   out  1                          sticky: saturate clamp or wrap occurred
// BEHAVIOUR
//   - Reset, asynchronous on reset_n=0: commit_valid=0, commit_size=0, instret=0, instret_ovf=0.
//     Clears any in-flight stage-1 value. Reset may land mid-burst; the first post-reset
//     output reflects only post-reset inputs.
//   - Stage 1, cycle N to N+1:
//     - a channel contributes popcount(ch_tmask slice) only when its ch_valid=1;
//       ch_tmask of an invalid channel is ignored;
//     - commit_size = sum of the channel contributions, computed at full SIZE_W with no truncation;
//     - commit_valid = (commit_size != 0); a valid channel with a zero mask contributes 0.
//   - Stage 2, cycle N+1 to N+2: instret update, evaluated in priority order:
//     1. csr_wr_en=1: the addressed half is replaced by csr_wr_data and the other half is
//        held. The stage-1 commit_size of that cycle is discarded, not added.
//        instret_ovf clears to 0.
//     2. else inhibit=1: instret holds and the stage-1 value is discarded.
//     3. else commit_valid=1: instret += commit_size.
//   - Latency: an input at cycle N is visible on commit_*  at N+1 and on instret at N+2.
//     Throughput is one commit set per cycle; the block has no backpressure.
//   - Wrap, SATURATE=0: the sum is taken modulo 2^CNT_WIDTH. instret_ovf sets on a
//     carry out of bit CNT_WIDTH-1.
//   - Saturate, SATURATE=1: if instret + commit_size >= 2^CNT_WIDTH, instret = all-ones
//     and instret_ovf sets. Once saturated, instret holds until a CSR write.
//   - A hi write with CNT_WIDTH<64 ignores csr_wr_data bits above CNT_WIDTH-33.
//   - Back-to-back lo and hi writes on consecutive cycles are each applied independently.
//     Commits arriving in between accumulate normally.
// TESTING
//   1. NUM_CHANNELS=6, NUM_THREADS=4, reset released; ch_valid=6'b000101, masks ch0=4'b1111,
//      ch2=4'b0011 -> commit_valid=1, commit_size=6 at N+1; instret=6 at N+2.
//   2. All 6 channels valid with full masks for 10 cycles -> commit_size=24 each cycle;
//      instret=240 two cycles after the last input.
//   3. csr_wr_en=1, csr_wr_hi=0, data=32'hFFFF_FFFE while size=3 commits are in flight ->
//      commit dropped, instret=0x0000_0000_FFFF_FFFE; the next size=3 commit gives
//      0x0000_0001_0000_0001 (carry into hi).
//   4. SATURATE=0, instret written to 2^64-2, then a size=5 commit -> instret=3, instret_ovf=1.
//      SATURATE=1, same stimulus -> instret=all-ones, instret_ovf=1; a later size=1 commit
//      leaves instret at all-ones.
//   5. inhibit=1 for 4 cycles of size=4 commits -> commit_size still 4, instret unchanged;
//      after inhibit drops, counting resumes the following cycle.
//   6. Assert reset_n=0 mid-burst -> all outputs 0 asynchronously. With valid inputs held
//      through release, commit_size reflects them at the first edge after release and
//      instret matches at the second edge.

Source files
------------

// File: rtl/vx_cmt_csr_counter.sv
// Commit-to-CSR aggregation: registered per-cycle lane popcount of valid commit
// channels, feeding a software-writable instret counter with wrap or saturate mode.
module vx_cmt_csr_counter #(
  parameter int unsigned NUM_CHANNELS = 6,
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned CNT_WIDTH    = 64,
  parameter bit          SATURATE     = 1'b0,
  localparam int unsigned SIZE_W      = $clog2(NUM_CHANNELS*NUM_THREADS+1)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_CHANNELS-1:0]             ch_valid,
  input  logic [NUM_CHANNELS*NUM_THREADS-1:0] ch_tmask,
  input  logic                                inhibit,
  input  logic                                csr_wr_en,
  input  logic                                csr_wr_hi,
  input  logic [31:0]                         csr_wr_data,
  output logic                                commit_valid,
  output logic [SIZE_W-1:0]                   commit_size,
  output logic [CNT_WIDTH-1:0]                instret,
  output logic                                instret_ovf
);

  localparam int unsigned EXT_W = CNT_WIDTH + 1;

  logic [SIZE_W-1:0]    size_d;
  logic [EXT_W-1:0]     sum_ext;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 ovf_d;

  // Stage 1: popcount of every valid channel's mask, summed at full width.
  always_comb begin
    size_d = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_valid[i]) begin
        for (int unsigned j = 0; j < NUM_THREADS; j++) begin
          size_d = size_d + SIZE_W'(ch_tmask[i*NUM_THREADS + j]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid <= 1'b0;
      commit_size  <= '0;
    end else begin
      commit_valid <= (size_d != '0);
      commit_size  <= size_d;
    end
  end

  // Stage 2: CSR write beats inhibit beats accumulation; the extra sum bit is the carry out.
  assign sum_ext = {1'b0, instret} + EXT_W'(commit_size);

  always_comb begin
    cnt_d = instret;
    ovf_d = instret_ovf;
    if (csr_wr_en) begin
      if (csr_wr_hi) begin
        cnt_d[CNT_WIDTH-1:32] = csr_wr_data[CNT_WIDTH-33:0];
      end else begin
        cnt_d[31:0] = csr_wr_data;
      end
      ovf_d = 1'b0;
    end else if (!inhibit && commit_valid) begin
      cnt_d = sum_ext[CNT_WIDTH-1:0];
      if (sum_ext[CNT_WIDTH]) begin
        ovf_d = 1'b1;
        if (SATURATE) begin
          cnt_d = '1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret     <= '0;
      instret_ovf <= 1'b0;
    end else begin
      instret     <= cnt_d;
      instret_ovf <= ovf_d;
    end
  end

endmodule

// File: tb/tb_vx_cmt_csr_counter.sv
// Bench for vx_cmt_csr_counter: a wrapping and a saturating instance share the
// same stimulus; directed table rows plus a hand-written mid-burst reset sequence.
module tb_vx_cmt_csr_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  ch_valid;
  logic [23:0] ch_tmask;
  logic        inhibit, csr_wr_en, csr_wr_hi;
  logic [31:0] csr_wr_data;

  logic        cv_w, cv_s, ovf_w, ovf_s;
  logic [4:0]  sz_w, sz_s;
  logic [63:0] inst_w, inst_s;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  vx_cmt_csr_counter #(.NUM_CHANNELS(6), .NUM_THREADS(4), .CNT_WIDTH(64), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_tmask(ch_tmask),
    .inhibit(inhibit), .csr_wr_en(csr_wr_en), .csr_wr_hi(csr_wr_hi), .csr_wr_data(csr_wr_data),
    .commit_valid(cv_w), .commit_size(sz_w), .instret(inst_w), .instret_ovf(ovf_w));

  vx_cmt_csr_counter #(.NUM_CHANNELS(6), .NUM_THREADS(4), .CNT_WIDTH(64), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_tmask(ch_tmask),
    .inhibit(inhibit), .csr_wr_en(csr_wr_en), .csr_wr_hi(csr_wr_hi), .csr_wr_data(csr_wr_data),
    .commit_valid(cv_s), .commit_size(sz_s), .instret(inst_s), .instret_ovf(ovf_s));

  typedef struct {
    logic [5:0]  valid;
    logic [23:0] tmask;
    logic        inh, wr_en, wr_hi;
    logic [31:0] wr_data;
    logic        exp_cv;
    logic [4:0]  exp_size;
    logic [63:0] exp_inst, exp_inst_sat;
    logic        exp_ovf, exp_ovf_sat;
  } row_t;

  row_t rows[$];

  task automatic check(input string name, input int unsigned idx, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic row_t mk(input logic [5:0] v, input logic [23:0] m, input logic inh,
                              input logic we, input logic wh, input logic [31:0] wd,
                              input logic cv, input logic [4:0] sz,
                              input logic [63:0] iw, input logic ow,
                              input logic [63:0] is, input logic os);
    row_t r;
    r.valid = v; r.tmask = m; r.inh = inh; r.wr_en = we; r.wr_hi = wh; r.wr_data = wd;
    r.exp_cv = cv; r.exp_size = sz;
    r.exp_inst = iw; r.exp_ovf = ow; r.exp_inst_sat = is; r.exp_ovf_sat = os;
    return r;
  endfunction

  // Row without overflow: both instances expected identical.
  function automatic row_t mk2(input logic [5:0] v, input logic [23:0] m, input logic inh,
                               input logic we, input logic wh, input logic [31:0] wd,
                               input logic cv, input logic [4:0] sz, input logic [63:0] iw);
    return mk(v, m, inh, we, wh, wd, cv, sz, iw, 1'b0, iw, 1'b0);
  endfunction

  task automatic drive(input logic [5:0] v, input logic [23:0] m, input logic inh,
                       input logic we, input logic wh, input logic [31:0] wd);
    ch_valid = v; ch_tmask = m; inhibit = inh;
    csr_wr_en = we; csr_wr_hi = wh; csr_wr_data = wd;
  endtask

  initial begin
    // Mask layout {ch5,ch4,ch3,ch2,ch1,ch0}, 4 bits each.
    rows.push_back(mk2(6'b000101, 24'h00_03_0F, 0, 0, 0, 0, 1, 6, 64'd0));
    rows.push_back(mk2(6'b000000, 24'h0,        0, 0, 0, 0, 0, 0, 64'd6));
    rows.push_back(mk2(6'b000000, 24'hFFFFFF,   0, 0, 0, 0, 0, 0, 64'd6));
    rows.push_back(mk2(6'b000010, 24'h00F000,   0, 0, 0, 0, 0, 0, 64'd6));
    rows.push_back(mk2(6'b111111, 24'h80F731,   0, 0, 0, 0, 1, 11, 64'd6));
    rows.push_back(mk2(6'b000000, 24'h0,        0, 0, 0, 0, 0, 0, 64'd17));
    for (int k = 0; k < 10; k++)
      rows.push_back(mk2(6'b111111, 24'hFFFFFF, 0, 0, 0, 0, 1, 24, 64'd17 + 64'(24*k)));
    rows.push_back(mk2(6'b000000, 24'h0, 0, 0, 0, 0, 0, 0, 64'd257));
    rows.push_back(mk2(6'b000000, 24'h0, 0, 0, 0, 0, 0, 0, 64'd257));
    // Lo write drops the in-flight size=3 commit, next commit carries into hi.
    rows.push_back(mk2(6'b000001, 24'h7, 0, 0, 0, 0,            1, 3, 64'd257));
    rows.push_back(mk2(6'b000001, 24'h7, 0, 1, 0, 32'hFFFF_FFFE, 1, 3, 64'h0000_0000_FFFF_FFFE));
    rows.push_back(mk2(6'b000000, 24'h0, 0, 0, 0, 0,            0, 0, 64'h0000_0001_0000_0001));
    rows.push_back(mk2(6'b000000, 24'h0, 0, 1, 1, 32'h2,        0, 0, 64'h0000_0002_0000_0001));
    // Back-to-back lo then hi writes.
    rows.push_back(mk2(6'b000001, 24'h1, 0, 1, 0, 32'h10, 1, 1, 64'h0000_0002_0000_0010));
    rows.push_back(mk2(6'b000000, 24'h0, 0, 1, 1, 32'h5,  0, 0, 64'h0000_0005_0000_0010));
    rows.push_back(mk2(6'b000000, 24'h0, 0, 0, 0, 0,      0, 0, 64'h0000_0005_0000_0010));
    // Inhibit for four size=4 commits, then counting resumes.
    for (int k = 0; k < 4; k++)
      rows.push_back(mk2(6'b000010, 24'h0000F0, 1, 0, 0, 0, 1, 4, 64'h0000_0005_0000_0010));
    rows.push_back(mk2(6'b000000, 24'h0, 0, 0, 0, 0, 0, 0, 64'h0000_0005_0000_0014));
    rows.push_back(mk2(6'b000000, 24'h0, 0, 0, 0, 0, 0, 0, 64'h0000_0005_0000_0014));
    // Overflow: write 2^64-2, commit 5.
    rows.push_back(mk2(6'b000000, 24'h0,  0, 1, 0, 32'hFFFF_FFFE, 0, 0, 64'h0000_0005_FFFF_FFFE));
    rows.push_back(mk2(6'b000011, 24'h1F, 0, 1, 1, 32'hFFFF_FFFF, 1, 5, 64'hFFFF_FFFF_FFFF_FFFE));
    rows.push_back(mk(6'b000001, 24'h1, 0, 0, 0, 0, 1, 1, 64'd3, 1, '1, 1));
    rows.push_back(mk(6'b000000, 24'h0, 0, 0, 0, 0, 0, 0, 64'd4, 1, '1, 1));
    rows.push_back(mk(6'b000000, 24'h0, 0, 1, 0, 32'h0, 0, 0, 64'd0, 0, 64'hFFFF_FFFF_0000_0000, 0));

    reset_n = 1'b0;
    drive('0, '0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_commit_valid", 0, 64'(cv_w), 64'd0);
    check("reset_commit_size",  0, 64'(sz_w), 64'd0);
    check("reset_instret",      0, inst_w,    64'd0);
    check("reset_ovf",          0, 64'(ovf_s), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i].valid, rows[i].tmask, rows[i].inh, rows[i].wr_en, rows[i].wr_hi, rows[i].wr_data);
      @(posedge clk);
      #1;
      check("commit_valid", i, 64'(cv_w),  64'(rows[i].exp_cv));
      check("commit_size",  i, 64'(sz_w),  64'(rows[i].exp_size));
      check("instret",      i, inst_w,     rows[i].exp_inst);
      check("instret_ovf",  i, 64'(ovf_w), 64'(rows[i].exp_ovf));
      check("sat_commit_size", i, 64'(sz_s), 64'(rows[i].exp_size));
      check("sat_instret",  i, inst_s,     rows[i].exp_inst_sat);
      check("sat_ovf",      i, 64'(ovf_s), 64'(rows[i].exp_ovf_sat));
    end

    // Mid-burst asynchronous reset with full commits held through release.
    drive(6'b111111, 24'hFFFFFF, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid",   100, 64'(cv_w),  64'd0);
    check("async_rst_size",    100, 64'(sz_w),  64'd0);
    check("async_rst_instret", 100, inst_w,     64'd0);
    check("async_rst_sat_ovf", 100, 64'(ovf_s), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_size",     101, 64'(sz_w), 64'd24);
    check("post_rst_instret",  101, inst_w,    64'd0);
    @(posedge clk);
    #1;
    check("post_rst_instret2", 102, inst_w,    64'd24);
    check("post_rst_sat",      102, inst_s,    64'd24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
